// File: rtl/jtcps1_colmix_if.sv
// -----------------------------------------------------------------------------
// jtcps1_colmix_if
// Palette RAM read port used by the CPS1 colour mixer.
//   pal_addr : 12-bit palette read address (driven by the mixer)
//   pal_data : 16-bit palette word {bright, R, G, B}, valid one clk after
//              pal_addr changes (driven by the palette RAM)
// The mixer only reads. There are no write strobes or request lines on this
// port.
// -----------------------------------------------------------------------------
interface jtcps1_colmix_if;
    logic [11:0] pal_addr;
    logic [15:0] pal_data;

    // master: the colour mixer (issues addresses, consumes data)
    modport master (output pal_addr, input pal_data);
    // slave: the palette RAM (consumes addresses, returns data)
    modport slave  (input pal_addr, output pal_data);
endinterface

// File: rtl/jtcps1_colmix.sv
// -----------------------------------------------------------------------------
// jtcps1_colmix
// Final colour stage of the CPS1 video path. It turns a 12-bit palette index
// into 8-bit RGB through palette RAM and the 4-bit brightness field.
//
// Pipeline (each step advances only on pxl_cen_i):
//   stage 0 : pal_addr <= pxl, capture HB/VB
//   stage 1 : capture palette word and the stage-0 blank bits
//   stage 2 : brightness-scale RGB, register LHBL/LVBL
// A sample's colour and blanking leave together on the third pxl_cen edge,
// counting the edge that samples it.
//
// Parameters
//   BLANK_BLACK : 1 forces RGB to black while the aligned blank is active
//
// Ports
//   clk, rst        : system clock, synchronous active-high reset
//   pxl_cen_i       : pixel clock enable (one clk wide, >= 2 clks apart)
//   pxl_i[11:0]     : colour index {page 3b, colour 5b, pen 4b}
//   HB_i, VB_i      : horizontal / vertical blank, active-high
//   pal             : palette RAM read port (master side)
//   red_o/green_o/blue_o : final 8-bit colour
//   LHBL_o, LVBL_o  : delayed blanking, active-low, aligned with RGB
// -----------------------------------------------------------------------------
module jtcps1_colmix #(
    parameter bit BLANK_BLACK = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pxl_cen_i,
    input  logic [11:0]            pxl_i,
    input  logic                   HB_i,
    input  logic                   VB_i,
    jtcps1_colmix_if.master        pal,
    output logic [7:0]             red_o,
    output logic [7:0]             green_o,
    output logic [7:0]             blue_o,
    output logic                   LHBL_o,
    output logic                   LVBL_o
);

    // Brightness scaling: floor({c,c} * (15 + 2*bright) / 45).
    // The largest product is 255*45 = 11475, so 14 bits hold it with no loss
    // before the constant divide.
    function automatic logic [7:0] scale_ch(input logic [3:0] c, input logic [3:0] bright);
        logic [5:0]  m;
        logic [13:0] prod;
        logic [13:0] quo;
        m    = 6'd15 + {1'b0, bright, 1'b0};
        prod = 14'({c, c}) * 14'(m);
        quo  = prod / 14'd45;
        return quo[7:0];
    endfunction

    // stage 0
    logic [11:0] addr_q, addr_d;
    logic        hb0_q, hb0_d, vb0_q, vb0_d;
    // stage 1
    logic [15:0] pal_q, pal_d;
    logic        hb1_q, hb1_d, vb1_q, vb1_d;
    // stage 2 (outputs)
    logic [7:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic        lhbl_q, lhbl_d, lvbl_q, lvbl_d;

    logic        blank1;
    logic [7:0]  red_s, green_s, blue_s;

    assign blank1  = hb1_q | vb1_q;
    assign red_s   = scale_ch(pal_q[11:8], pal_q[15:12]);
    assign green_s = scale_ch(pal_q[7:4],  pal_q[15:12]);
    assign blue_s  = scale_ch(pal_q[3:0],  pal_q[15:12]);

    always_comb begin
        addr_d  = addr_q;
        hb0_d   = hb0_q;
        vb0_d   = vb0_q;
        pal_d   = pal_q;
        hb1_d   = hb1_q;
        vb1_d   = vb1_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        lhbl_d  = lhbl_q;
        lvbl_d  = lvbl_q;
        if (pxl_cen_i) begin
            addr_d = pxl_i;
            hb0_d  = HB_i;
            vb0_d  = VB_i;
            // Palette data is taken as returned. A palette copy in progress
            // simply shows up on screen, with no interlock.
            pal_d  = pal.pal_data;
            hb1_d  = hb0_q;
            vb1_d  = vb0_q;
            if (BLANK_BLACK && blank1) begin
                red_d   = 8'd0;
                green_d = 8'd0;
                blue_d  = 8'd0;
            end else begin
                red_d   = red_s;
                green_d = green_s;
                blue_d  = blue_s;
            end
            lhbl_d = ~hb1_q;
            lvbl_d = ~vb1_q;
        end
    end

    // Reset wins over a coincident pxl_cen. Blank bits reset to "blanking",
    // so the first samples after reset leave as black and blanked.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= 12'd0;
            hb0_q   <= 1'b1;
            vb0_q   <= 1'b1;
            pal_q   <= 16'd0;
            hb1_q   <= 1'b1;
            vb1_q   <= 1'b1;
            red_q   <= 8'd0;
            green_q <= 8'd0;
            blue_q  <= 8'd0;
            lhbl_q  <= 1'b0;
            lvbl_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            hb0_q   <= hb0_d;
            vb0_q   <= vb0_d;
            pal_q   <= pal_d;
            hb1_q   <= hb1_d;
            vb1_q   <= vb1_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            lhbl_q  <= lhbl_d;
            lvbl_q  <= lvbl_d;
        end
    end

    assign pal.pal_addr = addr_q;
    assign red_o        = red_q;
    assign green_o      = green_q;
    assign blue_o       = blue_q;
    assign LHBL_o       = lhbl_q;
    assign LVBL_o       = lvbl_q;

endmodule

// File: tb/tb_jtcps1_colmix.sv
module tb_jtcps1_colmix;

    logic        clk = 1'b0;
    logic        rst;
    logic        pxl_cen;
    logic [11:0] pxl;
    logic        HB, VB;

    logic [7:0]  r1, g1, b1, r0, g0, b0;
    logic        lh1, lv1, lh0, lv0;

    logic [15:0] mem [0:4095];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jtcps1_colmix_if pif1 ();
    jtcps1_colmix_if pif0 ();

    // palette RAM model: one clk read latency
    always @(posedge clk) pif1.pal_data <= mem[pif1.pal_addr];
    always @(posedge clk) pif0.pal_data <= mem[pif0.pal_addr];

    jtcps1_colmix #(.BLANK_BLACK(1'b1)) dut1 (
        .clk(clk), .rst(rst), .pxl_cen_i(pxl_cen), .pxl_i(pxl), .HB_i(HB), .VB_i(VB),
        .pal(pif1.master), .red_o(r1), .green_o(g1), .blue_o(b1), .LHBL_o(lh1), .LVBL_o(lv1)
    );

    jtcps1_colmix #(.BLANK_BLACK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .pxl_cen_i(pxl_cen), .pxl_i(pxl), .HB_i(HB), .VB_i(VB),
        .pal(pif0.master), .red_o(r0), .green_o(g0), .blue_o(b0), .LHBL_o(lh0), .LVBL_o(lv0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ech(input int c, input int b);
        int v;
        v = (c * 17 * (15 + 2 * b)) / 45;
        return v[7:0];
    endfunction

    function automatic logic [31:0] expw(input logic [15:0] w);
        return {8'h0, ech(int'(w[11:8]), int'(w[15:12])),
                      ech(int'(w[7:4]),  int'(w[15:12])),
                      ech(int'(w[3:0]),  int'(w[15:12]))};
    endfunction

    // one pixel slot: pxl_cen high across exactly one rising edge, 4 clks per pixel
    task automatic pixel(input logic [11:0] p, input logic h, input logic v);
        @(negedge clk);
        pxl = p; HB = h; VB = v; pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    logic [11:0] baddr [0:7];
    logic        bhs   [0:7];
    logic        bvs   [0:7];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        mem[12'h123] = 16'hFF80;
        mem[12'h300] = 16'h0F10;
        mem[12'h301] = 16'hFF10;
        rst = 1'b1; pxl_cen = 1'b0; pxl = 12'h123; HB = 1'b0; VB = 1'b0;

        // reset state, with a coincident pxl_cen that must be ignored
        repeat (2) @(negedge clk);
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
        chk("rst_addr",  {20'h0, pif1.pal_addr}, 32'h0);
        chk("rst_rgb",   {8'h0, r1, g1, b1}, 32'h0);
        chk("rst_blank", {30'h0, lh1, lv1}, 32'h0);
        chk("rst_rgb0",  {8'h0, r0, g0, b0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // first two pixels after reset leave black and blanked, third is valid
        pixel(12'h123, 1'b0, 1'b0);
        chk("post_rst1_rgb",   {8'h0, r1, g1, b1}, 32'h0);
        chk("post_rst1_blank", {30'h0, lh1, lv1}, 32'h0);
        chk("addr_stage0",     {20'h0, pif1.pal_addr}, 32'h123);
        pixel(12'h123, 1'b0, 1'b0);
        chk("post_rst2_rgb",   {8'h0, r1, g1, b1}, 32'h0);
        chk("post_rst2_blank", {30'h0, lh1, lv1}, 32'h0);
        pixel(12'h123, 1'b0, 1'b0);
        chk("basic_rgb",   {8'h0, r1, g1, b1}, {8'h0, 8'd255, 8'd136, 8'd0});
        chk("basic_blank", {30'h0, lh1, lv1}, 32'h3);

        // brightness extremes for word {b, F, 1, 0}
        pixel(12'h300, 1'b0, 1'b0);
        pixel(12'h301, 1'b0, 1'b0);
        pixel(12'h301, 1'b0, 1'b0);
        chk("bright0",  {8'h0, r1, g1, b1}, {8'h0, 8'd85, 8'd5, 8'd0});
        pixel(12'h301, 1'b0, 1'b0);
        chk("bright15", {8'h0, r1, g1, b1}, {8'h0, 8'd255, 8'd17, 8'd0});

        // full (c, bright) sweep streamed back to back
        for (int s = 0; s < 256; s++) begin
            logic [7:0] sv;
            sv = 8'(s);
            mem[s] = {sv[7:4], sv[3:0], ~sv[3:0], sv[3:0] ^ 4'h5};
        end
        for (int k = 0; k < 258; k++) begin
            pixel((k < 256) ? 12'(k) : 12'h0, 1'b0, 1'b0);
            if (k >= 2) chk($sformatf("sweep%0d", k - 2), {8'h0, r1, g1, b1}, expw(mem[k - 2]));
        end

        // blanking alignment: HB on one pixel, VB on another
        for (int i = 0; i < 8; i++) begin
            baddr[i] = 12'h200 + 12'(i);
            mem[12'h200 + i] = {4'hF, 4'(i + 1), 4'(i + 3), 4'(15 - i)};
            bhs[i] = (i == 2);
            bvs[i] = (i == 4);
        end
        for (int k = 0; k < 8; k++) begin
            pixel(baddr[k], bhs[k], bvs[k]);
            if (k >= 2) begin
                logic [31:0] e;
                e = expw(mem[12'h200 + k - 2]);
                chk($sformatf("blk1_rgb%0d", k - 2), {8'h0, r1, g1, b1},
                    (bhs[k - 2] || bvs[k - 2]) ? 32'h0 : e);
                chk($sformatf("blk1_flags%0d", k - 2), {30'h0, lh1, lv1}, {30'h0, ~bhs[k - 2], ~bvs[k - 2]});
                chk($sformatf("blk0_rgb%0d", k - 2), {8'h0, r0, g0, b0}, e);
                chk($sformatf("blk0_flags%0d", k - 2), {30'h0, lh0, lv0}, {30'h0, ~bhs[k - 2], ~bvs[k - 2]});
            end
        end

        // reset mid-stream, coincident with pxl_cen during active video
        repeat (3) pixel(12'h123, 1'b0, 1'b0);
        chk("pre_rst_rgb", {8'h0, r1, g1, b1}, {8'h0, 8'd255, 8'd136, 8'd0});
        @(negedge clk);
        rst = 1'b1; pxl_cen = 1'b1; pxl = 12'h301;
        @(negedge clk);
        pxl_cen = 1'b0;
        chk("mid_rst_rgb",   {8'h0, r1, g1, b1}, 32'h0);
        chk("mid_rst_blank", {30'h0, lh1, lv1}, 32'h0);
        chk("mid_rst_addr",  {20'h0, pif1.pal_addr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pixel(12'h301, 1'b0, 1'b0);
        chk("mid_post1_rgb",   {8'h0, r1, g1, b1}, 32'h0);
        chk("mid_post1_blank", {30'h0, lh1, lv1}, 32'h0);
        pixel(12'h301, 1'b0, 1'b0);
        chk("mid_post2_rgb",   {8'h0, r1, g1, b1}, 32'h0);
        chk("mid_post2_blank", {30'h0, lh1, lv1}, 32'h0);
        pixel(12'h301, 1'b0, 1'b0);
        chk("mid_post3_rgb",   {8'h0, r1, g1, b1}, {8'h0, 8'd255, 8'd17, 8'd0});
        chk("mid_post3_blank", {30'h0, lh1, lv1}, 32'h3);

        // hold: no pxl_cen for 20 clks while everything else moves
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pxl = 12'($urandom);
            HB = ~HB;
            VB = (i % 3) == 0;
            mem[12'h301] = 16'($urandom);
            chk($sformatf("hold_rgb%0d", i),  {8'h0, r1, g1, b1}, {8'h0, 8'd255, 8'd17, 8'd0});
            chk($sformatf("hold_addr%0d", i), {20'h0, pif1.pal_addr}, 32'h301);
            chk($sformatf("hold_blank%0d", i), {30'h0, lh1, lv1}, 32'h3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
